// File: rtl/if_buf_pkg.sv
// Shared types, constants and parameter checks for the input-feature line buffer.
package if_buf_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_st_e;

    // Per-line side-band flags stored next to the data: {First, Last}
    localparam int FLAG_W = 2;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Legal parameter set: wide enough data, power-of-two depth, threshold inside 1..DEPTH
    function automatic bit params_ok(input int data_w, input int depth, input int afull_th);
        return (data_w >= 8) && is_pow2(depth) && (afull_th >= 1) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/if_fifo_mem.sv
// Line storage: DEPTH entries, one synchronous write port, one asynchronous read port.
// The array carries no reset; validity is tracked by the pointers and level in the top.
module if_fifo_mem #(
    parameter int WIDTH = 514,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the accepted line into its slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_line_fifo.sv
// Input-feature line buffer between the shared line bus and the MAC array.
// Level counts every stored line including the one presented at the head.
// The head is a registered copy of the oldest entry; it is refreshed from the
// entry that will be oldest after this edge, bypassing the bus when that entry
// is being written in the same cycle (push into an effectively empty buffer).
module if_line_fifo
    import if_buf_pkg::*;
#(
    parameter int DATA_W   = 512,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ShareValid_i,
    input  logic [DATA_W-1:0]          ShareLine_i,
    input  logic                       ShareFirst_i,
    input  logic                       ShareLast_i,
    output logic                       ShareReady_o,
    output logic                       Valid_o,
    output logic [DATA_W-1:0]          Data_o,
    output logic                       First_o,
    output logic                       Last_o,
    input  logic                       Halt_i,
    output logic [$clog2(DEPTH+1)-1:0] Level_o,
    output logic                       AlmostFull_o,
    output logic                       FrameErr_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + FLAG_W;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_TH);

    if (!params_ok(DATA_W, DEPTH, AFULL_TH)) begin : g_bad_params
        $error("if_line_fifo: illegal DATA_W/DEPTH/AFULL_TH combination");
    end

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [LVL_W-1:0]   level;
    logic [LVL_W-1:0]   level_nxt;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ENTRY_W-1:0] head_nxt;
    logic               push;
    logic               pop;
    logic               frame_viol;
    frame_st_e          frame_st;

    // Ready depends on the registered level only, never on Halt_i
    assign ShareReady_o = rstn & (level < DEPTH_LVL);
    assign push         = ShareValid_i & ShareReady_o;
    assign pop          = Valid_o & ~Halt_i;
    assign wr_entry     = {ShareFirst_i, ShareLast_i, ShareLine_i};
    assign Level_o      = level;
    assign AlmostFull_o = (level >= AFULL_LVL);

    if_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_nxt),
        .rd_data (rd_entry)
    );

    // Next read pointer, next level and next head contents
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        head_nxt   = rd_entry;
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = wr_entry;
        end
    end

    // Pointers, level and the registered head presented to the MAC array
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            Valid_o <= 1'b0;
            Data_o  <= '0;
            First_o <= 1'b0;
            Last_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr  <= rd_ptr_nxt;
            level   <= level_nxt;
            Valid_o <= (level_nxt != '0);
            if (level_nxt != '0) begin
                {First_o, Last_o, Data_o} <= head_nxt;
            end
        end
    end

    assign frame_viol = push & (((frame_st == IDLE) & ~ShareFirst_i) |
                                ((frame_st == IN_FRAME) & ShareFirst_i));

    // Frame FSM, advanced on accepted beats; flags bad framing one cycle later
    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_st   <= IDLE;
            FrameErr_o <= 1'b0;
        end else begin
            FrameErr_o <= frame_viol;
            if (push) begin
                if (ShareFirst_i) begin
                    frame_st <= ShareLast_i ? IDLE : IN_FRAME;
                end else if (ShareLast_i) begin
                    frame_st <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_line_fifo.sv
// Self-checking bench: queue-based reference model with a negedge scoreboard monitor.
module tb_if_line_fifo;

    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic          f;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sv = 1'b0, first = 1'b0, last = 1'b0, halt = 1'b0;
    logic [DW-1:0] line = '0;
    logic          ready, valid, first_o, last_o, afull, ferr;
    logic [DW-1:0] data_o;
    logic [2:0]    lvl;

    logic          sv2 = 1'b0, f2 = 1'b0, l2 = 1'b0, halt2 = 1'b0;
    logic [DW-1:0] line2 = '0;
    logic          ready2, valid2, first2_o, last2_o, afull2, ferr2;
    logic [DW-1:0] data2_o;
    logic [1:0]    lvl2;

    int    checks = 0;
    int    failures = 0;
    bit    armed = 1'b0;
    beat_t exp_q[$];
    bit    in_frame = 1'b0;
    bit    err_exp = 1'b0;
    int    errs_seen = 0;
    int    peak = 0;

    always #5 clk = ~clk;

    if_line_fifo #(.DATA_W(DW), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk(clk), .rstn(rstn),
        .ShareValid_i(sv), .ShareLine_i(line), .ShareFirst_i(first), .ShareLast_i(last),
        .ShareReady_o(ready), .Valid_o(valid), .Data_o(data_o), .First_o(first_o),
        .Last_o(last_o), .Halt_i(halt), .Level_o(lvl), .AlmostFull_o(afull),
        .FrameErr_o(ferr)
    );

    if_line_fifo #(.DATA_W(DW), .DEPTH(2), .AFULL_TH(1)) dut2 (
        .clk(clk), .rstn(rstn),
        .ShareValid_i(sv2), .ShareLine_i(line2), .ShareFirst_i(f2), .ShareLast_i(l2),
        .ShareReady_o(ready2), .Valid_o(valid2), .Data_o(data2_o), .First_o(first2_o),
        .Last_o(last2_o), .Halt_i(halt2), .Level_o(lvl2), .AlmostFull_o(afull2),
        .FrameErr_o(ferr2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare DUT against the model, then apply this cycle's pop/push
    always @(negedge clk) begin
        if (armed) begin
            if (!rstn) begin
                chk("ready_in_reset", 32'(ready), 32'd0);
                exp_q.delete();
                in_frame = 1'b0;
                err_exp  = 1'b0;
            end else begin
                int  sz;
                bit  bad;
                sz = exp_q.size();
                chk("level", 32'(lvl), 32'(sz));
                chk("valid", 32'(valid), 32'(sz != 0));
                chk("ready", 32'(ready), 32'(sz < 4));
                chk("almost_full", 32'(afull), 32'(sz >= 3));
                chk("frame_err", 32'(ferr), 32'(err_exp));
                if (ferr) errs_seen++;
                if (sz > peak) peak = sz;
                if (sz != 0) begin
                    chk("head_data", data_o, exp_q[0].d);
                    chk("head_first", 32'(first_o), 32'(exp_q[0].f));
                    chk("head_last", 32'(last_o), 32'(exp_q[0].l));
                end
                err_exp = 1'b0;
                if (sz != 0 && !halt) void'(exp_q.pop_front());
                if (sv && sz < 4) begin
                    beat_t b;
                    b.d = line; b.f = first; b.l = last;
                    exp_q.push_back(b);
                    bad = in_frame ? first : !first;
                    err_exp = bad;
                    if (first) in_frame = !last;
                    else if (last) in_frame = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic f, input logic l);
        int  n;
        bit  acc;
        n = 0; acc = 1'b0;
        sv = 1'b1; line = d; first = f; last = l;
        while (!acc) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout actual=%0d required=<200", n);
                break;
            end
        end
        sv = 1'b0;
    endtask

    task automatic drain();
        int n;
        halt = 1'b0; sv = 1'b0; n = 0;
        while (lvl != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_bounded", 32'(lvl), 32'd0);
    endtask

    initial begin
        int e0;
        bit acc;
        logic [DW-1:0] prev;

        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_level", 32'(lvl), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_data", data_o, 32'd0);
        @(posedge clk); #1;

        // 1: streaming with no halt
        peak = 0;
        send(32'hA1, 1'b1, 1'b0);
        send(32'hA2, 1'b0, 1'b0);
        send(32'hA3, 1'b0, 1'b0);
        send(32'hA4, 1'b0, 1'b1);
        drain();
        chk("t1_peak_level", 32'(peak), 32'd1);

        // 2: fill while halted, fifth beat held on the bus until release
        halt = 1'b1;
        send(32'hB1, 1'b1, 1'b0);
        send(32'hB2, 1'b0, 1'b0);
        send(32'hB3, 1'b0, 1'b0);
        send(32'hB4, 1'b0, 1'b0);
        fork
            send(32'hB5, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("t2_ready_full", 32'(ready), 32'd0);
                    chk("t2_level_full", 32'(lvl), 32'd4);
                end
                @(posedge clk); #1;
                halt = 1'b0;
            end
        join
        drain();

        // 3: full, one pop cycle with the bus beat waiting
        halt = 1'b1;
        send(32'hC1, 1'b1, 1'b0);
        send(32'hC2, 1'b0, 1'b0);
        send(32'hC3, 1'b0, 1'b0);
        send(32'hC4, 1'b0, 1'b0);
        sv = 1'b1; line = 32'hC5; first = 1'b0; last = 1'b1; halt = 1'b0;
        @(negedge clk);
        chk("t3_ready_when_full", 32'(ready), 32'd0);
        @(posedge clk); #1;
        chk("t3_level_after_pop", 32'(lvl), 32'd3);
        @(negedge clk);
        chk("t3_ready_after_pop", 32'(ready), 32'd1);
        @(posedge clk); #1;
        sv = 1'b0;
        chk("t3_level_push_pop", 32'(lvl), 32'd3);
        drain();

        // 4: framing violations
        errs_seen = 0;
        send(32'hD1, 1'b1, 1'b0);
        send(32'hD2, 1'b0, 1'b0);
        send(32'hD3, 1'b0, 1'b1);
        send(32'hD4, 1'b0, 1'b0);
        send(32'hD5, 1'b1, 1'b0);
        send(32'hD6, 1'b1, 1'b0);
        send(32'hD7, 1'b0, 1'b1);
        drain();
        @(posedge clk); #1;
        chk("t4_err_pulses", 32'(errs_seen), 32'd2);

        // 5: reset mid-frame with lines stored
        halt = 1'b1;
        send(32'hE1, 1'b1, 1'b0);
        send(32'hE2, 1'b0, 1'b0);
        send(32'hE3, 1'b0, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        halt = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_level", 32'(lvl), 32'd0);
        chk("t5_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        e0 = errs_seen;
        send(32'hE4, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t5_fsm_idle", 32'(errs_seen - e0), 32'd1);
        drain();

        // Random traffic with halts and occasional resets
        for (int c = 0; c < 600; c++) begin
            if (!sv && $urandom_range(0, 2) != 0) begin
                sv = 1'b1;
                line = $urandom;
                first = ($urandom_range(0, 3) == 0);
                last = ($urandom_range(0, 3) == 0);
            end
            halt = ($urandom_range(0, 3) == 0);
            rstn = ($urandom_range(0, 149) != 0);
            @(negedge clk);
            acc = sv && ready;
            @(posedge clk); #1;
            if (acc) sv = 1'b0;
        end
        rstn = 1'b1;
        drain();

        // 6: DEPTH=2 instance, threshold 1, pointer wrap
        halt2 = 1'b1;
        sv2 = 1'b1; line2 = 32'h55; f2 = 1'b1; l2 = 1'b1;
        @(negedge clk);
        chk("t6_ready_empty", 32'(ready2), 32'd1);
        @(posedge clk); #1;
        sv2 = 1'b0;
        @(negedge clk);
        chk("t6_afull", 32'(afull2), 32'd1);
        chk("t6_level", 32'(lvl2), 32'd1);
        chk("t6_data", data2_o, 32'h55);
        prev = 32'h55;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            halt2 = 1'b0;
            sv2 = 1'b1;
            line2 = 32'h100 + 32'(k);
            @(negedge clk);
            chk("t6_wrap_data", data2_o, prev);
            chk("t6_wrap_level", 32'(lvl2), 32'd1);
            chk("t6_wrap_ready", 32'(ready2), 32'd1);
            chk("t6_wrap_flags", 32'({first2_o, last2_o, ferr2}), 32'b110);
            prev = line2;
        end
        @(posedge clk); #1;
        sv2 = 1'b0;
        @(negedge clk);
        chk("t6_last_data", data2_o, prev);
        chk("t6_last_level", 32'(lvl2), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_empty_level", 32'(lvl2), 32'd0);
        chk("t6_empty_valid", 32'(valid2), 32'd0);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
